note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Queued tone scheduler in front of the speaker tone generator: CPU pushes {duration_ms, note} entries,
//  block plays them in order without CPU timing loops. Drives the tone register via note_out/note_load
//  using the note codes 60..96 the peripheral block already decodes (any other code = silence).
//  Sits beside peripherals on the peripheral bus; exposes FIFO/busy status for polling.
// PARAMETERS
//  TICKS_PER_MS  12000  clk cycles per millisecond (12 MHz raw clock); must be >= 2
//  DEPTH         8      FIFO entries; power of 2, 2..16
//  GAP_MS        10     silence inserted after every note, in ms; 0 = single-cycle gap
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  push         in   1   enqueue entry this cycle
//  entry        in   16  [15:8] duration in ms, [7:0] note code (0 = rest)
//  stop         in   1   abort playback, flush FIFO, silence speaker
//  clear_ovf    in   1   clear overflow flag
//  note_out     out  8   note code for tone register, held between load pulses
//  note_load    out  1   one-cycle strobe: write note_out to tone register
//  busy         out  1   state != IDLE or FIFO non-empty
//  fifo_count   out  5   entries queued, 0..DEPTH
//  full         out  1   fifo_count == DEPTH
//  empty        out  1   fifo_count == 0
//  overflow     out  1   sticky: a push was dropped
// BEHAVIOUR
//  Reset (async): FIFO pointers/count 0, state IDLE, note_out 0, note_load 0, overflow 0, counters 0.
//  All outputs registered; reset mid-note silences note_out at once, no load pulse issued.
//  FIFO: circular, DEPTH entries, wrap by pointer width. Push while full dropped, overflow<=1,
//   even if same-cycle pop. Pop only in LOAD. Push + pop same cycle: count unchanged.
//  States: IDLE, LOAD, PLAY, GAP.
//   IDLE: !empty -> LOAD.
//   LOAD: pop head. duration==0 -> skip entry, no pulse, -> IDLE.
//    Else note_out<=note, note_load<=1, ms_cnt<=duration, prescaler<=0 -> PLAY.
//   PLAY: prescaler counts 0..TICKS_PER_MS-1; on wrap ms_cnt decrements.
//    On the wrap where ms_cnt==1: note_out<=0, note_load<=1, load gap count -> GAP.
//    Silence strobe lands exactly duration*TICKS_PER_MS cycles after note strobe.
//   GAP: silent GAP_MS*TICKS_PER_MS cycles (1 cycle if GAP_MS==0) -> IDLE.
//  Latency: push on edge N into empty idle block -> note_load high after edge N+2.
//  Back-to-back: next note strobe 2 cycles after GAP ends if FIFO non-empty.
//  Rest (note 0): timed like a note; note_out 0 strobed at both start and end.
//  stop (highest priority, any state): FIFO flushed, count 0, same-cycle push dropped
//   (overflow unchanged), state IDLE. If state != IDLE: note_out<=0, note_load<=1 next cycle;
//   else no pulse.
//  clear_ovf with same-cycle dropped push: overflow stays 1 (set wins).
//  note_load never high two consecutive cycles except PLAY->GAP end strobe following a LOAD strobe
//   is impossible (TICKS_PER_MS >= 2).
//  ms_cnt 8 bits, prescaler $clog2(TICKS_PER_MS) bits; no other arithmetic.
// TESTING (TICKS_PER_MS=4, DEPTH=4, GAP_MS=1)
//  1 push 16'h0345 when idle -> note_load+note_out=69 two cycles later; note_out=0 strobe 12 cycles
//    after; busy falls 5 cycles after that.
//  2 push 5 entries 0x0140..0x0144 while playing first -> full=1, 5th dropped, overflow=1;
//    notes 0x40..0x43 strobed in order; clear_ovf -> overflow=0.
//  3 queue 0x0148, 0x0049, 0x014A -> strobes 0x48 then 0x4A only, no pulse for zero-duration entry.
//  4 stop 5 cycles into a 3 ms note with 2 queued -> next cycle note_load, note_out=0,
//    fifo_count=0, busy=0.
//  5 assert reset mid-PLAY -> note_out=0, note_load=0, fifo_count=0 without waiting for a clk edge.
//  6 push 16'h0200 (rest) -> two note_out=0 strobes 8 cycles apart; then push on same cycle
//    as GAP exit, verify wrap of pointers.

Source files
------------

// File: rtl/note_sequencer.sv
// Queued tone scheduler: plays {duration_ms, note} entries in order and
// strobes the tone register at note start, note end and on abort.
module note_sequencer #(
   parameter int TICKS_PER_MS = 12000,
   parameter int DEPTH        = 8,
   parameter int GAP_MS       = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [15:0] entry,
   input  logic        stop,
   input  logic        clear_ovf,
   output logic [7:0]  note_out,
   output logic        note_load,
   output logic        busy,
   output logic [4:0]  fifo_count,
   output logic        full,
   output logic        empty,
   output logic        overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PW-1:0] P_LAST  = PW'(TICKS_PER_MS - 1);
   localparam logic [4:0]    D_CNT   = 5'(DEPTH);
   localparam logic [7:0]    GAP_CNT = 8'(GAP_MS);

   typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

   state_t        state;
   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [7:0]    ms_cnt;
   logic [PW-1:0] prescaler;
   logic [15:0]   head;
   logic          do_push;
   logic          do_pop;
   logic          drop;
   logic [4:0]    count_next;

   assign head = mem[rd_ptr];

   always_comb begin
      drop       = push && !stop && (fifo_count == D_CNT);
      do_push    = push && !stop && (fifo_count != D_CNT);
      do_pop     = !stop && (state == LOAD);
      count_next = fifo_count;
      if (stop)
         count_next = 5'd0;
      else if (do_push && !do_pop)
         count_next = fifo_count + 5'd1;
      else if (!do_push && do_pop)
         count_next = fifo_count - 5'd1;
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= entry;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ms_cnt     <= 8'd0;
         prescaler  <= '0;
         note_out   <= 8'd0;
         note_load  <= 1'b0;
         busy       <= 1'b0;
         fifo_count <= 5'd0;
         full       <= 1'b0;
         empty      <= 1'b1;
         overflow   <= 1'b0;
      end else begin
         note_load  <= 1'b0;
         fifo_count <= count_next;
         full       <= (count_next == D_CNT);
         empty      <= (count_next == 5'd0);
         busy       <= !stop && ((state != IDLE) || (fifo_count != 5'd0));
         if (drop)
            overflow <= 1'b1;
         else if (clear_ovf)
            overflow <= 1'b0;
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (stop) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= IDLE;
            if (state != IDLE) begin
               note_out  <= 8'd0;
               note_load <= 1'b1;
            end
         end else begin
            unique case (state)
               IDLE: begin
                  if (fifo_count != 5'd0)
                     state <= LOAD;
               end
               LOAD: begin
                  // zero-duration entries are discarded without touching the speaker
                  if (head[15:8] == 8'd0) begin
                     state <= IDLE;
                  end else begin
                     note_out  <= head[7:0];
                     note_load <= 1'b1;
                     ms_cnt    <= head[15:8];
                     prescaler <= '0;
                     state     <= PLAY;
                  end
               end
               PLAY: begin
                  if (prescaler == P_LAST) begin
                     prescaler <= '0;
                     if (ms_cnt == 8'd1) begin
                        note_out  <= 8'd0;
                        note_load <= 1'b1;
                        ms_cnt    <= GAP_CNT;
                        state     <= GAP;
                     end else begin
                        ms_cnt <= ms_cnt - 8'd1;
                     end
                  end else begin
                     prescaler <= prescaler + PW'(1);
                  end
               end
               GAP: begin
                  // the gap reuses the note timers, counting GAP_MS down
                  if (GAP_MS == 0) begin
                     state <= IDLE;
                  end else if (prescaler == P_LAST) begin
                     prescaler <= '0;
                     if (ms_cnt == 8'd1)
                        state <= IDLE;
                     else
                        ms_cnt <= ms_cnt - 8'd1;
                  end else begin
                     prescaler <= prescaler + PW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a timeline model predicts strobe
// times and status; a monitor compares after every clock edge.
module tb_note_sequencer;

   localparam int TPM  = 4;
   localparam int DEP  = 4;
   localparam int GMS  = 1;
   localparam int GAPC = (GMS == 0) ? 1 : GMS * TPM;

   typedef struct {
      int         t;
      logic [7:0] n;
   } ev_t;

   logic        clk;
   logic        reset;
   logic        push;
   logic [15:0] entry;
   logic        stop;
   logic        clear_ovf;
   logic [7:0]  note_out;
   logic        note_load;
   logic        busy;
   logic [4:0]  fifo_count;
   logic        full;
   logic        empty;
   logic        overflow;

   note_sequencer #(
      .TICKS_PER_MS(TPM),
      .DEPTH(DEP),
      .GAP_MS(GMS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .push(push),
      .entry(entry),
      .stop(stop),
      .clear_ovf(clear_ovf),
      .note_out(note_out),
      .note_load(note_load),
      .busy(busy),
      .fifo_count(fifo_count),
      .full(full),
      .empty(empty),
      .overflow(overflow)
   );

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   ev_t         sb[$];
   logic [15:0] q[$];
   int          pop_at = -1;
   int          idle_from = 0;
   int          e_count = 0;
   bit          e_busy = 1'b0;
   bit          e_ovf = 1'b0;
   logic [7:0]  e_note = 8'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Effect of the coming clock edge, derived from the playback timeline.
   task automatic model_edge(input bit p, input logic [15:0] e,
                             input bit s, input bit c);
      int          k;
      bit          act;
      int          pre;
      int          d;
      logic [15:0] h;
      ev_t         ev;
      k   = cyc + 1;
      act = (pop_at == k) || (k < idle_from);
      pre = q.size();
      if (s) begin
         if (act) begin
            while (sb.size() > 0 && sb[$].t >= k)
               void'(sb.pop_back());
            ev.t = k;
            ev.n = 8'h00;
            sb.push_back(ev);
         end
         q.delete();
         pop_at    = -1;
         idle_from = k + 1;
         e_busy    = 1'b0;
      end else begin
         e_busy = act || (pre != 0);
         if (pop_at == k) begin
            h      = q.pop_front();
            d      = int'(h[15:8]);
            pop_at = -1;
            if (d == 0) begin
               idle_from = k + 1;
            end else begin
               ev.t = k;
               ev.n = h[7:0];
               sb.push_back(ev);
               ev.t = k + d * TPM;
               ev.n = 8'h00;
               sb.push_back(ev);
               idle_from = k + d * TPM + GAPC + 1;
            end
         end else if (k >= idle_from && pre != 0) begin
            pop_at = k + 1;
         end
         if (p && pre == DEP) begin
            e_ovf = 1'b1;
         end else begin
            if (p)
               q.push_back(e);
            if (c)
               e_ovf = 1'b0;
         end
      end
      e_count = q.size();
   endtask

   task automatic step(input bit p, input logic [15:0] e,
                       input bit s, input bit c);
      @(negedge clk);
      push      = p;
      entry     = e;
      stop      = s;
      clear_ovf = c;
      model_edge(p, e, s, c);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   always @(posedge clk) begin
      logic [8:0] st;
      logic [8:0] est;
      #1;
      if (reset) begin
         e_note = 8'd0;
      end else if (mon_en) begin
         if (note_load) begin
            checks++;
            if (sb.size() > 0 && sb[0].t == cyc) begin
               if (note_out !== sb[0].n) begin
                  errors++;
                  $display("FAIL strobe_note cyc=%0d got=%02h exp=%02h",
                           cyc, note_out, sb[0].n);
               end
               e_note = sb[0].n;
               void'(sb.pop_front());
            end else begin
               errors++;
               $display("FAIL unexpected_strobe cyc=%0d got=%02h exp=none",
                        cyc, note_out);
            end
         end else if (sb.size() > 0 && sb[0].t <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_strobe cyc=%0d got=none exp=%02h@%0d",
                     cyc, sb[0].n, sb[0].t);
            e_note = sb[0].n;
            void'(sb.pop_front());
         end
         checks++;
         if (note_out !== e_note) begin
            errors++;
            $display("FAIL note_hold cyc=%0d got=%02h exp=%02h",
                     cyc, note_out, e_note);
         end
         st  = {busy, full, empty, overflow, fifo_count};
         est = {e_busy, e_count == DEP, e_count == 0, e_ovf, 5'(e_count)};
         checks++;
         if (st !== est) begin
            errors++;
            $display("FAIL status cyc=%0d got=%b exp=%b (busy,full,empty,ovf,cnt)",
                     cyc, st, est);
         end
      end
   end

   task automatic reset_mid;
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if ({note_out, note_load, fifo_count, busy} !== 15'd0) begin
         errors++;
         $display("FAIL async_reset got=%02h/%b/%0d/%b exp=00/0/0/0",
                  note_out, note_load, fifo_count, busy);
      end
      q.delete();
      sb.delete();
      pop_at    = -1;
      idle_from = 0;
      e_count   = 0;
      e_busy    = 1'b0;
      e_ovf     = 1'b0;
      @(negedge clk);
      push      = 1'b0;
      stop      = 1'b0;
      clear_ovf = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      bit          p;
      bit          s;
      bit          c;
      logic [15:0] e;
      reset     = 1'b1;
      push      = 1'b0;
      entry     = 16'h0000;
      stop      = 1'b0;
      clear_ovf = 1'b0;
      repeat (3) @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;
      idle(3);

      step(1'b1, 16'h0345, 1'b0, 1'b0);
      idle(25);

      step(1'b1, 16'h0250, 1'b0, 1'b0);
      idle(4);
      for (int i = 0; i < 5; i++)
         step(1'b1, 16'h0140 + 16'(i), 1'b0, 1'b0);
      idle(70);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      idle(3);

      step(1'b1, 16'h0148, 1'b0, 1'b0);
      step(1'b1, 16'h0049, 1'b0, 1'b0);
      step(1'b1, 16'h014A, 1'b0, 1'b0);
      idle(40);

      step(1'b1, 16'h0345, 1'b0, 1'b0);
      step(1'b1, 16'h0146, 1'b0, 1'b0);
      step(1'b1, 16'h0147, 1'b0, 1'b0);
      idle(4);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      idle(10);

      step(1'b1, 16'h0A47, 1'b0, 1'b0);
      idle(8);
      reset_mid();
      idle(3);

      step(1'b1, 16'h0200, 1'b0, 1'b0);
      idle(13);
      step(1'b1, 16'h0151, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         step(1'b1, 16'h0152 + 16'(i), 1'b0, 1'b0);
      idle(60);

      for (int i = 0; i < 400; i++) begin
         p = ($urandom_range(0, 9) < 3);
         e = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
         s = ($urandom_range(0, 49) == 0);
         c = !s && ($urandom_range(0, 19) == 0);
         step(p, e, s, c);
      end
      idle(80);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending strobes exp=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
